// File: rtl/logic_unit_pkg.sv
// Shared definitions for the ALU-cluster bitwise logic unit.
// Holds the 3-bit opcode encoding used by the core and by the pipeline
// wrapper. Every encoding is a defined function, so no illegal-op handling
// exists anywhere downstream.
package logic_unit_pkg;

    localparam int LU_OP_W = 3;

    typedef enum logic [LU_OP_W-1:0] {
        LU_OP_AND  = 3'b000,
        LU_OP_OR   = 3'b001,
        LU_OP_XOR  = 3'b010,
        LU_OP_NOR  = 3'b011,
        LU_OP_NAND = 3'b100,
        LU_OP_XNOR = 3'b101,
        LU_OP_ANDN = 3'b110,  // a & ~b
        LU_OP_ORN  = 3'b111   // a | ~b
    } lu_op_e;

endpackage

// File: rtl/logic_unit_core.sv
// Combinational bitwise function unit with result flags.
// Ports:
//   op_i      function select (lu_op_e)
//   a_i, b_i  WIDTH-bit operands
//   result_o  selected bitwise function of a_i and b_i
//   zero_o    result_o is all zeros
//   ones_o    result_o is all ones
//   parity_o  XOR-reduction of result_o
module logic_unit_core
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  lu_op_e           op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o,
    output logic             ones_o,
    output logic             parity_o
);

    always_comb begin
        result_o = '0;
        case (op_i)
            LU_OP_AND:  result_o = a_i & b_i;
            LU_OP_OR:   result_o = a_i | b_i;
            LU_OP_XOR:  result_o = a_i ^ b_i;
            LU_OP_NOR:  result_o = ~(a_i | b_i);
            LU_OP_NAND: result_o = ~(a_i & b_i);
            LU_OP_XNOR: result_o = ~(a_i ^ b_i);
            LU_OP_ANDN: result_o = a_i & ~b_i;
            LU_OP_ORN:  result_o = a_i | ~b_i;
            default:    result_o = '0;
        endcase
    end

    assign zero_o   = (result_o == '0);
    assign ones_o   = &result_o;
    assign parity_o = ^result_o;

endmodule

// File: rtl/logic_unit_pipe.sv
// Pipelined bitwise logic unit with valid/ready handshake and sideband tag.
// The function and its flags are evaluated combinationally from the inputs
// and captured in stage 1; later stages only forward. Stall control is a
// single global enable, so bubbles travel with the data rather than being
// squeezed out.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   in_valid/in_ready       input handshake
//   in_op, in_a, in_b       function select and operands
//   in_tag                  sideband tag returned with the result
//   out_valid/out_ready     output handshake
//   out_result, out_tag     result and its tag
//   out_zero/ones/parity    registered flags of out_result
//   cnt_clear               synchronous clear of op_count (wins over count)
//   op_count                saturating count of output handshakes
module logic_unit_pipe
    import logic_unit_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2,
    parameter int TAG_W  = 4,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_zero,
    output logic             out_ones,
    output logic             out_parity,
    input  logic             cnt_clear,
    output logic [CNT_W-1:0] op_count
);

    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic [TAG_W-1:0] tag;
        logic             zero;
        logic             ones;
        logic             parity;
    } stage_t;

    stage_t           stage_d;
    stage_t           stage_q [STAGES];
    logic             vld_q   [STAGES];
    logic             advance;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    logic_unit_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .op_i     (lu_op_e'(in_op)),
        .a_i      (in_a),
        .b_i      (in_b),
        .result_o (stage_d.result),
        .zero_o   (stage_d.zero),
        .ones_o   (stage_d.ones),
        .parity_o (stage_d.parity)
    );

    assign stage_d.tag = in_tag;

    // The whole pipe moves together: it advances whenever the last stage is
    // empty or being drained this cycle.
    assign advance  = !vld_q[STAGES-1] || out_ready;
    assign in_ready = advance;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < STAGES; s++) begin
                vld_q[s]   <= 1'b0;
                stage_q[s] <= '0;
            end
        end else if (advance) begin
            // Payload may load on an idle input; only the valid bit matters.
            vld_q[0]   <= in_valid && in_ready;
            stage_q[0] <= stage_d;
            for (int s = 1; s < STAGES; s++) begin
                vld_q[s]   <= vld_q[s-1];
                stage_q[s] <= stage_q[s-1];
            end
        end
    end

    assign out_valid  = vld_q[STAGES-1];
    assign out_result = stage_q[STAGES-1].result;
    assign out_tag    = stage_q[STAGES-1].tag;
    assign out_zero   = stage_q[STAGES-1].zero;
    assign out_ones   = stage_q[STAGES-1].ones;
    assign out_parity = stage_q[STAGES-1].parity;

    // Clear beats increment, so a handshake in a clear cycle is dropped.
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clear) begin
            cnt_d = '0;
        end else if (out_valid && out_ready && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign op_count = cnt_q;

endmodule

// File: tb/tb_logic_unit_pipe.sv
module tb_logic_unit_pipe;

    localparam int N = 3;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  tag;
        logic [2:0]  flg;   // {zero, ones, parity}
        int          acc;
        int          stl;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic        iv   [N];
    logic        orr  [N];
    logic        clr  [N];
    logic [2:0]  opi  [N];
    logic [31:0] a    [N];
    logic [31:0] b    [N];
    logic [3:0]  tg   [N];

    logic [N-1:0] ir, ov, zf, onf, pf;
    logic [31:0]  res0;
    logic [7:0]   res1, res2;
    logic [3:0]   otg0, otg1, otg2;
    logic [15:0]  cnt0;
    logic [2:0]   cnt1, cnt2;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int stalls [N];
    logic hold [N];
    logic [31:0] pres [N];
    logic [3:0]  ptag [N];
    int cmodel [N];
    exp_t q0[$], q1[$], q2[$];

    logic_unit_pipe #(.WIDTH(32), .STAGES(2), .TAG_W(4), .CNT_W(16)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .in_op(opi[0]),
        .in_a(a[0]), .in_b(b[0]), .in_tag(tg[0]), .out_valid(ov[0]), .out_ready(orr[0]),
        .out_result(res0), .out_tag(otg0), .out_zero(zf[0]), .out_ones(onf[0]),
        .out_parity(pf[0]), .cnt_clear(clr[0]), .op_count(cnt0));

    logic_unit_pipe #(.WIDTH(8), .STAGES(4), .TAG_W(4), .CNT_W(3)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .in_op(opi[1]),
        .in_a(a[1][7:0]), .in_b(b[1][7:0]), .in_tag(tg[1]), .out_valid(ov[1]), .out_ready(orr[1]),
        .out_result(res1), .out_tag(otg1), .out_zero(zf[1]), .out_ones(onf[1]),
        .out_parity(pf[1]), .cnt_clear(clr[1]), .op_count(cnt1));

    logic_unit_pipe #(.WIDTH(8), .STAGES(1), .TAG_W(4), .CNT_W(3)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]), .in_op(opi[2]),
        .in_a(a[2][7:0]), .in_b(b[2][7:0]), .in_tag(tg[2]), .out_valid(ov[2]), .out_ready(orr[2]),
        .out_result(res2), .out_tag(otg2), .out_zero(zf[2]), .out_ones(onf[2]),
        .out_parity(pf[2]), .cnt_clear(clr[2]), .op_count(cnt2));

    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    // ---------------- per-instance helpers ----------------
    function automatic int stages_of(int k);
        return (k == 0) ? 2 : (k == 1) ? 4 : 1;
    endfunction
    function automatic int width_of(int k);
        return (k == 0) ? 32 : 8;
    endfunction
    function automatic int cmax_of(int k);
        return (k == 0) ? 65535 : 7;
    endfunction
    function automatic logic [31:0] o_res(int k);
        case (k)
            0:       return res0;
            1:       return {24'd0, res1};
            default: return {24'd0, res2};
        endcase
    endfunction
    function automatic logic [3:0] o_tag(int k);
        case (k)
            0:       return otg0;
            1:       return otg1;
            default: return otg2;
        endcase
    endfunction
    function automatic int o_cnt(int k);
        case (k)
            0:       return int'(cnt0);
            1:       return int'(cnt1);
            default: return int'(cnt2);
        endcase
    endfunction
    function automatic logic [2:0] o_flg(int k);
        return {zf[k], onf[k], pf[k]};
    endfunction

    function automatic int qsize(int k);
        case (k)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction
    function automatic exp_t qfront(int k);
        case (k)
            0:       return q0[0];
            1:       return q1[0];
            default: return q2[0];
        endcase
    endfunction
    task automatic qpop(input int k);
        case (k)
            0:       void'(q0.pop_front());
            1:       void'(q1.pop_front());
            default: void'(q2.pop_front());
        endcase
    endtask
    task automatic qpush(input int k, input exp_t e);
        case (k)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask
    task automatic qclear(input int k);
        case (k)
            0:       q0.delete();
            1:       q1.delete();
            default: q2.delete();
        endcase
    endtask

    task automatic chk(input int k, input string nm, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL dut%0d %s: got %0h required %0h (cycle %0d)", k, nm, act, req, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    // Each opcode is a 2-input truth table indexed by {a_bit, b_bit}.
    function automatic logic [3:0] truth(logic [2:0] o);
        case (o)
            3'd0:    return 4'b1000;  // AND
            3'd1:    return 4'b1110;  // OR
            3'd2:    return 4'b0110;  // XOR
            3'd3:    return 4'b0001;  // NOR
            3'd4:    return 4'b0111;  // NAND
            3'd5:    return 4'b1001;  // XNOR
            3'd6:    return 4'b0100;  // ANDN
            default: return 4'b1101;  // ORN
        endcase
    endfunction

    function automatic exp_t model(int k, logic [2:0] o, logic [31:0] x, logic [31:0] y, logic [3:0] t);
        exp_t e;
        logic [3:0] tt;
        int w;
        int ones;
        tt = truth(o);
        w = width_of(k);
        ones = 0;
        e.res = '0;
        for (int i = 0; i < w; i++) begin
            e.res[i] = tt[{x[i], y[i]}];
            ones += int'(e.res[i]);
        end
        e.tag = t;
        e.flg = {ones == 0, ones == w, (ones % 2) == 1};
        e.acc = 0;
        e.stl = 0;
        return e;
    endfunction

    // ---------------- monitor / scoreboard ----------------
    task automatic mon(input int k);
        exp_t e;
        if (!rst_n) begin
            qclear(k);
            hold[k] = 1'b0;
            cmodel[k] = 0;
            return;
        end
        chk(k, "in_ready", 64'(ir[k]), 64'(!ov[k] || orr[k]));
        if (ov[k]) begin
            chk(k, "result_expected_when_valid", 64'(qsize(k) > 0), 64'd1);
            if (qsize(k) > 0) begin
                e = qfront(k);
                if (hold[k]) begin
                    chk(k, "stall_result_stable", 64'(o_res(k)), 64'(pres[k]));
                    chk(k, "stall_tag_stable", 64'(o_tag(k)), 64'(ptag[k]));
                end else begin
                    chk(k, "latency", 64'(cyc), 64'(e.acc + stages_of(k) + stalls[k] - e.stl));
                end
                if (orr[k]) begin
                    qpop(k);
                    chk(k, "result", 64'(o_res(k)), 64'(e.res));
                    chk(k, "tag", 64'(o_tag(k)), 64'(e.tag));
                    chk(k, "flags", 64'(o_flg(k)), 64'(e.flg));
                end
            end
        end
        chk(k, "op_count", 64'(o_cnt(k)), 64'(cmodel[k]));
        if (clr[k]) cmodel[k] = 0;
        else if (ov[k] && orr[k] && cmodel[k] < cmax_of(k)) cmodel[k]++;
        hold[k] = ov[k] && !orr[k];
        if (hold[k]) begin
            stalls[k]++;
            pres[k] = o_res(k);
            ptag[k] = o_tag(k);
        end
        if (iv[k] && ir[k]) begin
            e = model(k, opi[k], a[k], b[k], tg[k]);
            e.acc = cyc;
            e.stl = stalls[k];
            qpush(k, e);
        end
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < N; k++) mon(k);
    end

    // ---------------- drivers ----------------
    task automatic send(input int k, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [3:0] t);
        int n;
        iv[k] = 1'b1; opi[k] = o; a[k] = x; b[k] = y; tg[k] = t;
        n = 0;
        @(negedge clk);
        while (!ir[k] && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk(k, "accept_timeout", 64'(n), 64'd0);
        @(posedge clk);
        #1;
        iv[k] = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain(input int k);
        int n;
        n = 0;
        while (qsize(k) != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (n >= 200) chk(k, "drain_timeout", 64'(qsize(k)), 64'd0);
    endtask

    task automatic wait_valid_then(input int k);
        int n;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!ov[k] && n < 50);
        if (n >= 50) chk(k, "out_valid_timeout", 64'(ov[k]), 64'd1);
    endtask

    task automatic random_phase(input int k, input int nops);
        bit done;
        int g;
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < nops; i++) begin
                    if ($urandom_range(3) == 0) idle(1);
                    send(k, 3'($urandom_range(7)), $urandom, $urandom, 4'($urandom_range(15)));
                end
                done = 1'b1;
            end
            begin
                g = 0;
                while (!done && g < 2000) begin
                    @(posedge clk);
                    #1;
                    orr[k] = ($urandom_range(3) != 0);
                    g++;
                end
                orr[k] = 1'b1;
            end
        join
        drain(k);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        for (int k = 0; k < N; k++) begin
            iv[k] = 1'b0; orr[k] = 1'b1; clr[k] = 1'b0;
            opi[k] = '0; a[k] = '0; b[k] = '0; tg[k] = '0;
            stalls[k] = 0; hold[k] = 1'b0; cmodel[k] = 0; pres[k] = '0; ptag[k] = '0;
        end

        // Reset state
        rst_n = 1'b0;
        idle(3);
        for (int k = 0; k < N; k++) begin
            chk(k, "rst_out_valid", 64'(ov[k]), 64'd0);
            chk(k, "rst_out_result", 64'(o_res(k)), 64'd0);
            chk(k, "rst_out_tag", 64'(o_tag(k)), 64'd0);
            chk(k, "rst_flags", 64'(o_flg(k)), 64'd0);
            chk(k, "rst_op_count", 64'(o_cnt(k)), 64'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        for (int k = 0; k < N; k++) chk(k, "in_ready_after_reset", 64'(ir[k]), 64'd1);
        idle(1);

        // Opcode sweep, back-to-back, tags 0..7
        for (int i = 0; i < 8; i++) send(0, 3'(i), 32'hF0F0_00FF, 32'h0FF0_0F0F, 4'(i));
        // Flag corners
        send(0, 3'b011, 32'h0, 32'h0, 4'd8);
        send(0, 3'b000, 32'h1, 32'h3, 4'd9);
        drain(0);

        // Randomized traffic with random backpressure on every instance
        for (int k = 0; k < N; k++) random_phase(k, 30);

        // Backpressure: 3 stalled cycles starting at the first out_valid
        clr[0] = 1'b1;
        idle(1);
        clr[0] = 1'b0;
        fork
            for (int i = 0; i < 6; i++) send(0, 3'($urandom_range(7)), $urandom, $urandom, 4'(i));
            begin
                wait_valid_then(0);
                orr[0] = 1'b0;
                idle(3);
                orr[0] = 1'b1;
            end
        join
        drain(0);
        chk(0, "op_count_after_backpressure", 64'(cnt0), 64'd6);

        // Reset with two operations in flight
        send(0, 3'b001, 32'h1234_5678, 32'h0F0F_0F0F, 4'd3);
        send(0, 3'b010, 32'hAAAA_5555, 32'hFFFF_0000, 4'd4);
        rst_n = 1'b0;
        #1;
        chk(0, "midrst_out_valid", 64'(ov[0]), 64'd0);
        chk(0, "midrst_op_count", 64'(cnt0), 64'd0);
        idle(2);
        rst_n = 1'b1;
        @(negedge clk);
        chk(0, "in_ready_after_midrst", 64'(ir[0]), 64'd1);
        idle(6);
        chk(0, "no_stale_output", 64'(ov[0]), 64'd0);

        // Deep pipe, narrow width: XNOR of equal operands
        send(1, 3'b101, 32'hA5, 32'hA5, 4'd1);
        drain(1);
        // Counter saturation on the 3-bit counter
        clr[1] = 1'b1;
        idle(1);
        clr[1] = 1'b0;
        for (int i = 0; i < 9; i++) send(1, 3'($urandom_range(7)), $urandom, $urandom, 4'(i));
        drain(1);
        chk(1, "op_count_saturated", 64'(cnt1), 64'd7);
        // Clear during a handshake cycle
        fork
            for (int i = 0; i < 4; i++) send(1, 3'($urandom_range(7)), $urandom, $urandom, 4'(i));
            begin
                wait_valid_then(1);
                clr[1] = 1'b1;
                idle(1);
                clr[1] = 1'b0;
                chk(1, "op_count_clear_in_handshake", 64'(cnt1), 64'd0);
            end
        join
        drain(1);

        // Single-stage pipe
        send(2, 3'b101, 32'hA5, 32'hA5, 4'd2);
        for (int i = 0; i < 5; i++) send(2, 3'($urandom_range(7)), $urandom, $urandom, 4'(i));
        drain(2);

        idle(3);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/logic_unit_pipe.md
Name: logic_unit_pipe

Overview:
- Parametrised, pipelined bitwise logic unit for the RISC datapath ALU cluster; replaces the single-function combinational NOR unit.
- Computes one of eight two-operand bitwise functions on WIDTH-bit operands, plus zero, all-ones and parity flags.
- Result passes through a STAGES-deep register pipeline with a valid/ready handshake and a sideband tag.
- Keeps a saturating count of completed operations for the performance monitor.

Parameters:
- WIDTH, 32: operand and result width, >= 2.
- STAGES, 2: pipeline register depth, 1..4; latency in cycles.
- TAG_W, 4: width of sideband tag carried with each operation, >= 1.
- CNT_W, 16: width of the completed-operation counter.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operation presented.
- in_ready  out  1  unit accepts operation this cycle.
- in_op  in  3  function select, see Behaviour.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- in_tag  in  TAG_W  sideband tag, returned unchanged.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_result  out  WIDTH  function result.
- out_tag  out  TAG_W  tag of this result.
- out_zero  out  1  out_result == 0.
- out_ones  out  1  out_result == all ones.
- out_parity  out  1  XOR-reduction of out_result.
- cnt_clear  in  1  synchronous clear of op_count.
- op_count  out  CNT_W  number of completed output handshakes, saturating.

Behaviour:
- Reset (asynchronous, active-low):
  - All stage valid bits are 0.
  - out_valid, out_result, out_tag, out_zero, out_ones, out_parity and op_count are all 0.
  - in_ready goes to 1 once reset is released.
- Opcodes:
  - 000 AND, 001 OR, 010 XOR, 011 NOR.
  - 100 NAND, 101 XNOR.
  - 110 ANDN (a & ~b), 111 ORN (a | ~b).
  - All opcodes are defined; there is no illegal-op path.
- Function and flags are evaluated combinationally from in_* and captured into stage 1. Stages 2..STAGES forward result, tag, flags and valid unchanged.
- Stall control is global:
  - advance = !out_valid || out_ready.
  - in_ready = advance.
  - When advance = 1, every stage loads from its predecessor; stage 1 loads in_valid && in_ready.
  - When advance = 0, every stage holds, and out_* stays stable while out_valid = 1.
  - Bubbles are not compressed.
- Latency: an operation accepted in cycle N appears with out_valid = 1 in cycle N+STAGES if no stall occurs.
- Throughput: one operation per cycle when out_ready is held at 1.
- An input handshake is in_valid && in_ready. An output handshake is out_valid && out_ready. Both may occur in the same cycle.
- in_* is don't-care when in_valid = 0. Payload registers may load, but the valid bit must stay 0.
- op_count:
  - Increments on each output handshake and saturates at 2^CNT_W-1.
  - cnt_clear has priority over increment; a handshake in a clear cycle is not counted.
- Reset asserted mid-operation discards all in-flight operations with no partial output.
- Flags are always computed from the full WIDTH result. They are registered, never recomputed at the output.

Decomposition:
- Shared ALU package holds:
  - LU_OP_* 3-bit opcode constants.
  - The opcode typedef.
- Natural sub-module: logic_unit_core, a combinational function plus flag computation, WIDTH-parametrised.
- logic_unit_pipe instantiates logic_unit_core and implements the stage registers, stall control and counter.

Test Plan:
- Reset: assert rst_n=0 mid-stream with 2 operations in flight, release -> out_valid=0, op_count=0, no stale results; in_ready=1 on the first cycle after release.
- Opcode sweep, WIDTH=32, STAGES=2, out_ready=1, a=32'hF0F0_00FF, b=32'h0FF0_0F0F, in_op 000..111 on consecutive cycles:
  - Each result arrives 2 cycles after acceptance, in order with matching tags 0..7.
  - NOR result = 32'h000F_F000; XOR result = 32'hFF00_0FF0.
- Flags:
  - NOR with a=b=0 -> result 32'hFFFF_FFFF, out_ones=1, out_zero=0, out_parity=0.
  - AND with a=1, b=3 -> result 1, out_parity=1, out_zero=0.
- Backpressure: stream 6 ops with out_ready held low for 3 cycles after the first out_valid:
  - in_ready=0 during the stall.
  - out_result and out_tag are held stable.
  - All 6 results delivered exactly once, in order.
  - op_count=6.
- Counter, CNT_W=3: 9 back-to-back handshakes -> op_count saturates at 7. cnt_clear asserted in a handshake cycle -> op_count=0 the next cycle.
- Parameter corners: STAGES=1 and STAGES=4, WIDTH=8 -> latency is 1 and 4 cycles respectively. XNOR with a=8'hA5, b=8'hA5 -> 8'hFF.
